dram_timer_bank: RTL and testbench

DRAM_TIMER_BANK -- requirements
Module: dram_timer_bank

---
 rtl/dram_timer_bank.sv | 145 ++++++++++++++
 tb/tb_dram_timer_bank.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_timer_bank.sv
// dram_timer_bank: a bank of independent DRAM timing-constraint down-counters
// plus a refresh-interval generator with a postponed-refresh credit counter.
// Optional feature macro: DRAM_TIMER_OVF_EN adds the sticky ref_ovf output,
// which flags any refresh tick lost because the credit counter was full.
module dram_timer_bank #(
    parameter int WIDTH        = 8,
    parameter int CHANNELS     = 4,
    parameter int REFI         = 7800,
    parameter int MAX_POSTPONE = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic [CHANNELS-1:0]       ld,
    input  logic [CHANNELS*WIDTH-1:0] ld_val,
    output logic [CHANNELS*WIDTH-1:0] count,
    output logic [CHANNELS-1:0]       ready,
    output logic                      ref_req,
    input  logic                      ref_ack,
    output logic                      ref_urgent,
    output logic [3:0]                ref_pending
`ifdef DRAM_TIMER_OVF_EN
    ,
    output logic                      ref_ovf
`endif
);

    localparam logic [WIDTH-1:0] CNT_ONE   = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [15:0]      INTV_LAST = 16'(REFI - 1);
    localparam logic [3:0]       PEND_MAX  = 4'(MAX_POSTPONE);

    // ---------------------------------------------------------------
    // Per-channel constraint timers
    // ---------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_chan
            logic [WIDTH-1:0] count_reg;
            logic [WIDTH-1:0] count_next;

            // Load wins over decrement; decrement stops at zero.
            always_comb begin
                count_next = count_reg;
                if (ld[gi]) begin
                    count_next = ld_val[gi*WIDTH +: WIDTH];
                end else if (en && (count_reg != '0)) begin
                    count_next = count_reg - CNT_ONE;
                end
            end

            // Timer state register.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    count_reg <= '0;
                end else begin
                    count_reg <= count_next;
                end
            end

            assign count[gi*WIDTH +: WIDTH] = count_reg;
            assign ready[gi]                = (count_reg == '0);
        end
    endgenerate

    // ---------------------------------------------------------------
    // Refresh interval generator
    // ---------------------------------------------------------------
    logic [15:0] intv_reg;
    logic [15:0] intv_next;
    logic        tick;

    // Interval advances only on enabled cycles; tick marks the wrap.
    always_comb begin
        tick      = en && (intv_reg == INTV_LAST);
        intv_next = intv_reg;
        if (en) begin
            intv_next = tick ? 16'd0 : intv_reg + 16'd1;
        end
    end

    // Interval counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            intv_reg <= 16'd0;
        end else begin
            intv_reg <= intv_next;
        end
    end

    // ---------------------------------------------------------------
    // Outstanding refresh credits
    // ---------------------------------------------------------------
    logic [3:0] pend_reg;
    logic [3:0] pend_next;

    // A tick adds a credit, an ack retires one; both together cancel
    // unless nothing was outstanding, in which case the ack is ignored.
    always_comb begin
        pend_next = pend_reg;
        case ({tick, ref_ack})
            2'b10: begin
                if (pend_reg != PEND_MAX) pend_next = pend_reg + 4'd1;
            end
            2'b01: begin
                if (pend_reg != 4'd0) pend_next = pend_reg - 4'd1;
            end
            2'b11: begin
                if (pend_reg == 4'd0) pend_next = 4'd1;
            end
            default: pend_next = pend_reg;
        endcase
    end

    // Credit counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_reg <= 4'd0;
        end else begin
            pend_reg <= pend_next;
        end
    end

    assign ref_pending = pend_reg;
    assign ref_req     = (pend_reg != 4'd0);
    assign ref_urgent  = (pend_reg == PEND_MAX);

`ifdef DRAM_TIMER_OVF_EN
    logic ovf_reg;
    logic tick_drop;

    assign tick_drop = tick && !ref_ack && (pend_reg == PEND_MAX);

    // Sticky flag for a refresh tick lost at saturation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_reg <= 1'b0;
        end else if (tick_drop) begin
            ovf_reg <= 1'b1;
        end
    end

    assign ref_ovf = ovf_reg;
`endif

endmodule

// File: tb/tb_dram_timer_bank.sv
// tb_dram_timer_bank: table of timer/refresh vectors fed through an
// expected-value queue, plus hand-written refresh and reset sequences.
// Build with DRAM_TIMER_OVF_EN defined to also exercise ref_ovf.
module tb_dram_timer_bank;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  ld;
    logic [31:0] ld_val;
    logic [31:0] count;
    logic [3:0]  ready;
    logic        ref_req;
    logic        ref_ack;
    logic        ref_urgent;
    logic [3:0]  ref_pending;
`ifdef DRAM_TIMER_OVF_EN
    logic        ref_ovf;
`endif

    int checks = 0;
    int errors = 0;

    dram_timer_bank #(
        .WIDTH(8), .CHANNELS(4), .REFI(16), .MAX_POSTPONE(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .en(en),
        .ld(ld),
        .ld_val(ld_val),
        .count(count),
        .ready(ready),
        .ref_req(ref_req),
        .ref_ack(ref_ack),
        .ref_urgent(ref_urgent),
        .ref_pending(ref_pending)
`ifdef DRAM_TIMER_OVF_EN
        ,
        .ref_ovf(ref_ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  ld;
        logic [31:0] ld_val;
        logic        en;
        logic        ack;
        logic [31:0] exp_count;
        logic [3:0]  exp_ready;
        logic [3:0]  exp_pend;
    } vec_t;

    vec_t tbl[26];
    vec_t exp_q[$];

    function automatic vec_t mk(input logic [3:0] l, input logic [31:0] v,
                                input logic e, input logic a,
                                input logic [31:0] c, input logic [3:0] r,
                                input logic [3:0] p);
        vec_t t;
        t.ld = l; t.ld_val = v; t.en = e; t.ack = a;
        t.exp_count = c; t.exp_ready = r; t.exp_pend = p;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input logic e, input logic a);
        en = e;
        ref_ack = a;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; ld = '0; ld_val = '0; en = 1'b0; ref_ack = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        ld = v.ld; ld_val = v.ld_val; en = v.en; ref_ack = v.ack;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check($sformatf("row%0d_count", idx), count, e.exp_count);
        check($sformatf("row%0d_ready", idx), {28'd0, ready}, {28'd0, e.exp_ready});
        check($sformatf("row%0d_pend", idx), {28'd0, ref_pending}, {28'd0, e.exp_pend});
        check($sformatf("row%0d_req", idx), {31'd0, ref_req}, {31'd0, (e.exp_pend != 4'd0)});
        check($sformatf("row%0d_urgent", idx), {31'd0, ref_urgent}, {31'd0, (e.exp_pend == 4'd2)});
        $display("row %0d ld=%b val=%h en=%b ack=%b -> count=%h ready=%b pend=%0d",
                 idx, v.ld, v.ld_val, v.en, v.ack, count, ready, ref_pending);
    endtask

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        // Timer scenarios; pend column tracks refresh ticks (every 16th enabled edge).
        tbl[0]  = mk(4'b0010, 32'h00000300, 0, 0, 32'h00000300, 4'b1101, 0);
        tbl[1]  = mk(4'b0011, 32'h00000005, 1, 0, 32'h00000005, 4'b1110, 0);
        tbl[2]  = mk(4'b0000, 32'h00000000, 1, 0, 32'h00000004, 4'b1110, 0);
        tbl[3]  = mk(4'b0000, 32'h00000000, 1, 0, 32'h00000003, 4'b1110, 0);
        tbl[4]  = mk(4'b0000, 32'h00000000, 1, 0, 32'h00000002, 4'b1110, 0);
        tbl[5]  = mk(4'b0000, 32'h00000000, 1, 0, 32'h00000001, 4'b1110, 0);
        tbl[6]  = mk(4'b0000, 32'h00000000, 1, 0, 32'h00000000, 4'b1111, 0);
        tbl[7]  = mk(4'b0000, 32'h00000000, 1, 0, 32'h00000000, 4'b1111, 0);
        tbl[8]  = mk(4'b0100, 32'h000A0000, 1, 0, 32'h000A0000, 4'b1011, 0);
        tbl[9]  = mk(4'b0000, 32'h00000000, 1, 0, 32'h00090000, 4'b1011, 0);
        tbl[10] = mk(4'b0000, 32'h00000000, 0, 0, 32'h00090000, 4'b1011, 0);
        tbl[11] = mk(4'b0000, 32'h00000000, 0, 0, 32'h00090000, 4'b1011, 0);
        tbl[12] = mk(4'b0000, 32'h00000000, 0, 0, 32'h00090000, 4'b1011, 0);
        tbl[13] = mk(4'b0000, 32'h00000000, 1, 0, 32'h00080000, 4'b1011, 0);
        tbl[14] = mk(4'b0000, 32'h00000000, 1, 0, 32'h00070000, 4'b1011, 0);
        tbl[15] = mk(4'b0000, 32'h00000000, 1, 0, 32'h00060000, 4'b1011, 0);
        tbl[16] = mk(4'b0000, 32'h00000000, 1, 0, 32'h00050000, 4'b1011, 0);
        tbl[17] = mk(4'b0000, 32'h00000000, 1, 0, 32'h00040000, 4'b1011, 0);
        tbl[18] = mk(4'b0100, 32'h00070000, 1, 0, 32'h00070000, 4'b1011, 0);
        tbl[19] = mk(4'b0000, 32'h00000000, 1, 0, 32'h00060000, 4'b1011, 1);
        tbl[20] = mk(4'b0000, 32'h00000000, 1, 0, 32'h00050000, 4'b1011, 1);
        tbl[21] = mk(4'b0000, 32'h00000000, 0, 1, 32'h00050000, 4'b1011, 0);
        tbl[22] = mk(4'b0000, 32'h00000000, 0, 1, 32'h00050000, 4'b1011, 0);
        tbl[23] = mk(4'b1111, 32'h04030201, 0, 0, 32'h04030201, 4'b0000, 0);
        tbl[24] = mk(4'b0000, 32'h00000000, 1, 0, 32'h03020100, 4'b0001, 0);
        tbl[25] = mk(4'b0001, 32'h000000FF, 1, 0, 32'h020100FF, 4'b0010, 0);

        // Reset state.
        rst = 1'b0; ld = '0; ld_val = '0; en = 1'b0; ref_ack = 1'b0;
        #2;
        check("rst_count", count, 32'h0);
        check("rst_ready", {28'd0, ready}, 32'hF);
        check("rst_pend", {28'd0, ref_pending}, 32'h0);
        check("rst_req", {31'd0, ref_req}, 32'h0);
        check("rst_urgent", {31'd0, ref_urgent}, 32'h0);
        $display("reset state count=%h ready=%b pend=%0d", count, ready, ref_pending);

        do_reset();
        for (int i = 0; i < 26; i++) apply(i, tbl[i]);
        ld = '0;

        // Countdown of 10 with three disabled cycles reaches ready after 13 edges.
        do_reset();
        ld = 4'b0100; ld_val = 32'h000A0000;
        step(1'b1, 1'b0);
        ld = '0;
        n = 0;
        while (!ready[2] && n < 40) begin
            step(!(n >= 3 && n < 6), 1'b0);
            n++;
        end
        check("ch2_ready_latency", n, 13);
        $display("ch2 ready after %0d cycles", n);

        // Refresh accumulation to saturation with no acks.
        do_reset();
        for (int c = 1; c <= 48; c++) begin
            step(1'b1, 1'b0);
            if (c == 15) check("ref_c15_pend", {28'd0, ref_pending}, 32'd0);
            if (c == 16) begin
                check("ref_c16_pend", {28'd0, ref_pending}, 32'd1);
                check("ref_c16_req", {31'd0, ref_req}, 32'd1);
                check("ref_c16_urgent", {31'd0, ref_urgent}, 32'd0);
            end
            if (c == 32) begin
                check("ref_c32_pend", {28'd0, ref_pending}, 32'd2);
                check("ref_c32_urgent", {31'd0, ref_urgent}, 32'd1);
`ifdef DRAM_TIMER_OVF_EN
                check("ref_c32_ovf", {31'd0, ref_ovf}, 32'd0);
`endif
            end
            if (c == 48) begin
                check("ref_c48_pend", {28'd0, ref_pending}, 32'd2);
                check("ref_c48_urgent", {31'd0, ref_urgent}, 32'd1);
`ifdef DRAM_TIMER_OVF_EN
                check("ref_c48_ovf", {31'd0, ref_ovf}, 32'd1);
`endif
            end
        end
        $display("saturation run pend=%0d urgent=%b", ref_pending, ref_urgent);

        // Ack interplay with ticks.
        do_reset();
        for (int c = 0; c < 16; c++) step(1'b1, 1'b0);
        check("ack_pre_pend", {28'd0, ref_pending}, 32'd1);
        for (int c = 0; c < 15; c++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("ack_on_tick_pend", {28'd0, ref_pending}, 32'd1);
        step(1'b0, 1'b1);
        check("ack_retire_pend", {28'd0, ref_pending}, 32'd0);
        step(1'b0, 1'b1);
        check("ack_idle_pend", {28'd0, ref_pending}, 32'd0);
        check("ack_idle_req", {31'd0, ref_req}, 32'd0);
        for (int c = 0; c < 15; c++) step(1'b1, 1'b0);
        step(1'b1, 1'b1);
        check("ack_tick_zero_pend", {28'd0, ref_pending}, 32'd1);
        $display("ack sequence pend=%0d req=%b", ref_pending, ref_req);

        // Asynchronous reset with live state, then interval restart.
        do_reset();
        for (int c = 0; c < 48; c++) step(1'b1, 1'b0);
        ld = 4'b1000; ld_val = 32'h32000000;
        step(1'b0, 1'b0);
        ld = '0;
        check("pre_rst_count", count, 32'h32000000);
        check("pre_rst_pend", {28'd0, ref_pending}, 32'd2);
        rst = 1'b0;
        #1;
        check("async_rst_count", count, 32'h0);
        check("async_rst_ready", {28'd0, ready}, 32'hF);
        check("async_rst_pend", {28'd0, ref_pending}, 32'd0);
        check("async_rst_req", {31'd0, ref_req}, 32'd0);
        check("async_rst_urgent", {31'd0, ref_urgent}, 32'd0);
`ifdef DRAM_TIMER_OVF_EN
        check("async_rst_ovf", {31'd0, ref_ovf}, 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b1;
        for (int c = 0; c < 15; c++) step(1'b1, 1'b0);
        check("post_rst_c15_pend", {28'd0, ref_pending}, 32'd0);
        step(1'b1, 1'b0);
        check("post_rst_c16_pend", {28'd0, ref_pending}, 32'd1);
        $display("post reset tick pend=%0d", ref_pending);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
